// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush control unit.
// Holds FSM encoding, the canonical NOP and the hazard-detection helper.
package hazard_flush_ctrl_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StSquash = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_X0    = 5'd0;

  // A load writing a non-x0 rd that the decode instruction actually reads.
  function automatic logic is_load_use(
    input logic       ex_load,
    input logic       ex_reg_write,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_rs1_used,
    input logic       id_rs2_used
  );
    logic w_rs1_hit;
    logic w_rs2_hit;
    w_rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    w_rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    return ex_load && ex_reg_write && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush generation for the IF/ID and ID/EX registers: load-use interlock,
// wrong-path squash after EX redirects, and saturating stall/redirect counters.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_load_in,
  input  logic             ex_reg_write_in,
  input  logic [4:0]       ex_rd_in,
  input  logic [4:0]       id_rs1_in,
  input  logic [4:0]       id_rs2_in,
  input  logic             id_rs1_used_in,
  input  logic             id_rs2_used_in,
  input  logic             ex_branch_taken_in,
  input  logic             ex_jalr_in,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             redirect_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_sq_cnt;
  logic [1:0] w_sq_cnt_d;
  logic       r_redirect_active;

  logic w_load_use;
  logic w_redirect;
  logic w_stall_inc;
  logic w_redir_inc;

  assign w_load_use = is_load_use(ex_load_in, ex_reg_write_in, ex_rd_in, id_rs1_in, id_rs2_in,
                                  id_rs1_used_in, id_rs2_used_in);
  assign w_redirect = ex_branch_taken_in | ex_jalr_in;

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    w_stall_inc = 1'b0;
    w_redir_inc = 1'b0;
    w_state_d   = r_state;
    w_sq_cnt_d  = r_sq_cnt;

    if (rst) begin
      if (w_redirect) begin
        // Redirect wins over load-use: the dependent instruction is wrong-path.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        w_redir_inc = 1'b1;
        if (BUBBLES != 2'd0) begin
          w_state_d  = StSquash;
          w_sq_cnt_d = BUBBLES;
        end else begin
          w_state_d  = StRun;
          w_sq_cnt_d = 2'd0;
        end
      end else begin
        unique case (r_state)
          StRun: begin
            if (w_load_use) begin
              pc_stall    = 1'b1;
              if_id_stall = 1'b1;
              id_ex_flush = 1'b1;
              w_stall_inc = 1'b1;
            end
          end
          StSquash: begin
            if_id_flush = 1'b1;
            if (r_sq_cnt <= 2'd1) begin
              w_state_d  = StRun;
              w_sq_cnt_d = 2'd0;
            end else begin
              w_sq_cnt_d = r_sq_cnt - 2'd1;
            end
          end
          default: begin
            w_state_d  = StRun;
            w_sq_cnt_d = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= StRun;
      r_sq_cnt          <= 2'd0;
      r_redirect_active <= 1'b0;
    end else begin
      r_state           <= w_state_d;
      r_sq_cnt          <= w_sq_cnt_d;
      r_redirect_active <= (w_state_d == StSquash);
    end
  end

  assign redirect_active = r_redirect_active;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redir_inc),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: three instances (1 bubble, 3 bubbles,
// 4-bit counters) share stimulus; each step checks hand-computed values.
module tb_hazard_flush_ctrl;

  logic       clk;
  logic       rst;
  logic       ex_load_in;
  logic       ex_reg_write_in;
  logic [4:0] ex_rd_in;
  logic [4:0] id_rs1_in;
  logic [4:0] id_rs2_in;
  logic       id_rs1_used_in;
  logic       id_rs2_used_in;
  logic       ex_branch_taken_in;
  logic       ex_jalr_in;

  logic        d1_pc_stall, d1_if_id_stall, d1_if_id_flush, d1_id_ex_flush, d1_ra;
  logic [31:0] d1_stall_count, d1_redirect_count;
  logic        d3_pc_stall, d3_if_id_stall, d3_if_id_flush, d3_id_ex_flush, d3_ra;
  logic [31:0] d3_stall_count, d3_redirect_count;
  logic        d4_pc_stall, d4_if_id_stall, d4_if_id_flush, d4_id_ex_flush, d4_ra;
  logic [3:0]  d4_stall_count, d4_redirect_count;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_flush_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .ex_load_in(ex_load_in), .ex_reg_write_in(ex_reg_write_in),
    .ex_rd_in(ex_rd_in), .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
    .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
    .ex_branch_taken_in(ex_branch_taken_in), .ex_jalr_in(ex_jalr_in),
    .pc_stall(d1_pc_stall), .if_id_stall(d1_if_id_stall), .if_id_flush(d1_if_id_flush),
    .id_ex_flush(d1_id_ex_flush), .redirect_active(d1_ra),
    .stall_count(d1_stall_count), .redirect_count(d1_redirect_count)
  );

  hazard_flush_ctrl #(.REDIRECT_BUBBLES(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .ex_load_in(ex_load_in), .ex_reg_write_in(ex_reg_write_in),
    .ex_rd_in(ex_rd_in), .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
    .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
    .ex_branch_taken_in(ex_branch_taken_in), .ex_jalr_in(ex_jalr_in),
    .pc_stall(d3_pc_stall), .if_id_stall(d3_if_id_stall), .if_id_flush(d3_if_id_flush),
    .id_ex_flush(d3_id_ex_flush), .redirect_active(d3_ra),
    .stall_count(d3_stall_count), .redirect_count(d3_redirect_count)
  );

  hazard_flush_ctrl #(.REDIRECT_BUBBLES(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .ex_load_in(ex_load_in), .ex_reg_write_in(ex_reg_write_in),
    .ex_rd_in(ex_rd_in), .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
    .id_rs1_used_in(id_rs1_used_in), .id_rs2_used_in(id_rs2_used_in),
    .ex_branch_taken_in(ex_branch_taken_in), .ex_jalr_in(ex_jalr_in),
    .pc_stall(d4_pc_stall), .if_id_stall(d4_if_id_stall), .if_id_flush(d4_if_id_flush),
    .id_ex_flush(d4_id_ex_flush), .redirect_active(d4_ra),
    .stall_count(d4_stall_count), .redirect_count(d4_redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the four control outputs of dut1 as {pc_stall, if_id_stall, if_id_flush, id_ex_flush}.
  function automatic logic [31:0] ctl1();
    return {28'd0, d1_pc_stall, d1_if_id_stall, d1_if_id_flush, d1_id_ex_flush};
  endfunction

  function automatic logic [31:0] ctl3();
    return {28'd0, d3_pc_stall, d3_if_id_stall, d3_if_id_flush, d3_id_ex_flush};
  endfunction

  function automatic logic [31:0] ctl4();
    return {28'd0, d4_pc_stall, d4_if_id_stall, d4_if_id_flush, d4_id_ex_flush};
  endfunction

  task automatic idle();
    ex_load_in = 1'b0; ex_reg_write_in = 1'b0; ex_rd_in = 5'd0;
    id_rs1_in = 5'd0; id_rs2_in = 5'd0; id_rs1_used_in = 1'b0; id_rs2_used_in = 1'b0;
    ex_branch_taken_in = 1'b0; ex_jalr_in = 1'b0;
  endtask

  task automatic load_use_rs1();
    idle();
    ex_load_in = 1'b1; ex_reg_write_in = 1'b1; ex_rd_in = 5'd5;
    id_rs1_in = 5'd5; id_rs1_used_in = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    load_use_rs1();
    #2;
    chk("reset_ctl_forced_0", ctl1(), 32'h0);
    chk("reset_ra", {31'd0, d1_ra}, 32'h0);
    @(posedge clk); #1;
    chk("reset_stall_cnt", d1_stall_count, 32'd0);
    chk("reset_redir_cnt", d1_redirect_count, 32'd0);

    @(negedge clk); rst = 1'b1; idle(); #1;
    chk("idle_ctl", ctl1(), 32'h0);

    // Load-use on rs1: stall for exactly one cycle.
    @(negedge clk); load_use_rs1(); #1;
    chk("lu_ctl", ctl1(), 32'b1101);
    @(posedge clk); #1;
    chk("lu_stall_cnt", d1_stall_count, 32'd1);
    @(negedge clk); idle(); #1;
    chk("lu_cleared", ctl1(), 32'h0);

    @(negedge clk); load_use_rs1(); ex_rd_in = 5'd0; id_rs1_in = 5'd0; #1;
    chk("lu_x0_ctl", ctl1(), 32'h0);
    @(posedge clk); #1;
    chk("lu_x0_cnt", d1_stall_count, 32'd1);

    @(negedge clk); load_use_rs1(); id_rs1_in = 5'd3; id_rs2_in = 5'd5; #1;
    chk("rs2_unused_ctl", ctl1(), 32'h0);
    @(posedge clk); #1;
    chk("rs2_unused_cnt", d1_stall_count, 32'd1);

    // Branch redirect with one bubble.
    @(negedge clk); idle(); ex_branch_taken_in = 1'b1; #1;
    chk("br_c0_ctl", ctl1(), 32'b0011);
    @(posedge clk); #1;
    chk("br_ra", {31'd0, d1_ra}, 32'h1);
    chk("br_redir_cnt", d1_redirect_count, 32'd1);
    @(negedge clk); idle(); #1;
    chk("br_c1_ctl", ctl1(), 32'b0010);
    @(posedge clk); #1;
    chk("br_ra_drop", {31'd0, d1_ra}, 32'h0);
    @(negedge clk); #1;
    chk("br_c2_ctl", ctl1(), 32'h0);

    // jalr together with load-use: redirect wins.
    @(negedge clk); load_use_rs1(); ex_jalr_in = 1'b1; #1;
    chk("jalr_lu_ctl", ctl1(), 32'b0011);
    @(posedge clk); #1;
    chk("jalr_lu_stall_cnt", d1_stall_count, 32'd1);
    chk("jalr_lu_redir_cnt", d1_redirect_count, 32'd2);

    // New redirect arriving during SQUASH, load-use also present (ignored).
    @(negedge clk); load_use_rs1(); ex_branch_taken_in = 1'b1; #1;
    chk("resq_ctl", ctl1(), 32'b0011);
    @(posedge clk); #1;
    chk("resq_redir_cnt", d1_redirect_count, 32'd3);
    chk("resq_ra", {31'd0, d1_ra}, 32'h1);
    @(negedge clk); load_use_rs1(); #1;
    chk("sq_ignores_lu", ctl1(), 32'b0010);
    @(posedge clk); #1;
    chk("sq_lu_stall_cnt", d1_stall_count, 32'd1);
    @(negedge clk); idle(); #1;
    chk("resq_done_ctl", ctl1(), 32'h0);
    chk("resq_done_ra", {31'd0, d1_ra}, 32'h0);
    chk("d4_redir_cnt", {28'd0, d4_redirect_count}, 32'd3);

    // Reset in the second squash cycle of the 3-bubble instance.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("d3_post_rst_cnt", d3_redirect_count, 32'd0);
    @(negedge clk); ex_branch_taken_in = 1'b1; #1;
    chk("d3_br_c0_ctl", ctl3(), 32'b0011);
    @(posedge clk); #1;
    chk("d3_ra_sq1", {31'd0, d3_ra}, 32'h1);
    chk("d3_redir_cnt", d3_redirect_count, 32'd1);
    @(negedge clk); idle(); #1;
    chk("d3_sq1_ctl", ctl3(), 32'b0010);
    @(negedge clk); #1;
    chk("d3_sq2_ctl", ctl3(), 32'b0010);
    chk("d3_sq2_ra", {31'd0, d3_ra}, 32'h1);
    #1 rst = 1'b0; #1;
    chk("d3_rst_ctl", ctl3(), 32'h0);
    chk("d3_rst_ra", {31'd0, d3_ra}, 32'h0);
    chk("d3_rst_redir_cnt", d3_redirect_count, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("d3_rel_ctl", ctl3(), 32'h0);
    @(posedge clk); #1;
    chk("d3_rel_ra", {31'd0, d3_ra}, 32'h0);
    @(negedge clk); #1;
    chk("d3_rel_run_ctl", ctl3(), 32'h0);

    // Saturation of the 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); load_use_rs1();
      @(posedge clk); #1;
      if (i == 13) chk("d4_cnt_14", {28'd0, d4_stall_count}, 32'd14);
      if (i == 14) chk("d4_cnt_15", {28'd0, d4_stall_count}, 32'd15);
    end
    chk("d4_ctl_still_stall", ctl4(), 32'b1101);
    chk("d4_cnt_sat", {28'd0, d4_stall_count}, 32'd15);
    chk("d1_cnt_20", d1_stall_count, 32'd20);
    @(negedge clk); idle(); #1;
    chk("final_idle_ctl", ctl4(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
